pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the instruction pointer and sequences fetch: increments, stalls, redirects and flushes.
//  Takes jump/branch/call/return requests from decode/execute.
//  Picks one redirect per cycle by fixed priority and drives the next IP to instruction memory.
//  Signals a fixed-length pipeline flush after every redirect. Sits between execute and the fetch stage.
// PARAMETERS
//  ADDR_W        10  IP width; all IP arithmetic is modulo 2^ADDR_W
//  FLUSH_CYCLES  2   cycles oFlush stays high per redirect (legal range 1..7)
//  RESET_VECTOR  0   IP presented after reset
//  RAS_DEPTH     4   return-address-stack entries (used only with PC_RAS_EN)
// PORTS
//  Clock           in   1       clock, rising edge
//  Reset           in   1       synchronous, active-high
//  iStall          in   1       hold current IP (fetch back-pressure)
//  iJumpTaken      in   1       absolute jump request
//  iBranchTaken    in   1       relative branch request
//  iCall           in   1       call request: jump to iJumpAddress, push return address
//  iRet            in   1       return request: pop return address
//  iJumpAddress    in   ADDR_W  absolute target for jump/call
//  iBranchOffset   in   6       sign-magnitude offset: [5]=1 subtract, [4:0]=magnitude
//  iBranchIP       in   ADDR_W  IP of the requesting branch/call instruction
//  oIP             out  ADDR_W  fetch address
//  oIPValid        out  1       oIP is a fetch to be executed
//  oFlush          out  1       squash in-flight instructions younger than the redirect
//  oState          out  2       0 IDLE, 1 RUN, 2 FLUSH
//  oRasError       out  1       1-cycle pulse on RAS overflow/underflow
// BEHAVIOUR
//  Reset values: oIP=RESET_VECTOR, oIPValid=0, oFlush=0, oState=IDLE, oRasError=0.
//   - Reset wins over every other input in any state, including mid-FLUSH; it clears the RAS.
//  IDLE: first edge with Reset low -> RUN. oIP stays RESET_VECTOR, oIPValid=1.
//  RUN, no request:
//   - iStall=1 -> oIP holds.
//   - else oIP <= oIP+1; 2^ADDR_W-1 wraps to 0.
//  RUN, one or more requests: priority is Jump > Call > Ret > Branch.
//   - Only the winner acts; losers are dropped, not queued.
//   - A redirect overrides iStall.
//  Targets (next edge):
//   - jump/call: iJumpAddress
//   - ret: popped RAS entry
//   - branch: iBranchIP +/- iBranchOffset[4:0], zero-extended, modulo 2^ADDR_W
//  On the redirect edge: oIP <= target, oFlush=1, oIPValid=0, state -> FLUSH.
//  FLUSH:
//   - Holds oIP; counter loads FLUSH_CYCLES-1 and counts down.
//   - At 0 -> RUN, oFlush=0, oIPValid=1, oIP=target (not incremented).
//   - Requests and iStall arriving during FLUSH are ignored.
//  Latency: request at edge N -> oIP=target visible after edge N+1.
//   - Target first fetched valid after edge N+FLUSH_CYCLES+1.
//  oState changes registered, same edge as oIP.
// CONFIGURATION
//  PC_RAS_EN defined: RAS_DEPTH-entry circular stack.
//   - Call pushes iBranchIP+1 (wrapped).
//   - Ret pops into target.
//   - Push when full overwrites oldest, pulses oRasError.
//   - Pop when empty targets RESET_VECTOR, pulses oRasError.
//  PC_RAS_EN undefined: no stack.
//   - iCall behaves exactly as iJumpTaken.
//   - iRet ignored (no redirect, no flush).
//   - oRasError tied 0.
// TESTING
//  1. Reset 3 cycles, release, no requests -> IDLE 1 cycle, then oIP 0,0,1,2,3... with oIPValid=1.
//  2. oIP=0x3FE free-run -> 0x3FF then 0x000; iStall for 2 cycles at 0x005 -> oIP holds 0x005 for 2 cycles.
//  3. iBranchTaken, iBranchIP=0x010, offset=6'b100011 -> oIP=0x00D; oFlush high 2 cycles, oIPValid=0.
//     Then oIP=0x00D valid, then 0x00E.
//  4. Same-cycle iJumpTaken(0x200) and iBranchTaken(offset +4) -> oIP=0x200, single flush; branch dropped.
//  5. Branch issued mid-FLUSH -> ignored; Reset asserted mid-FLUSH -> oIP=0, oFlush=0, IDLE next cycle.
//  6. PC_RAS_EN: call at iBranchIP=0x020 -> 0x100; ret -> 0x021.
//     5 calls with depth 4 -> oRasError on 5th; ret on empty -> oIP=0, oRasError=1.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the instruction pointer and sequences fetch.
// Free-runs or stalls the IP, applies one redirect per cycle (Jump > Call > Ret > Branch)
// and follows every redirect with a fixed-length flush window.
// Optional macro PC_RAS_EN adds a circular return-address stack for call/return;
// without it a call is a plain jump, a return is ignored and oRasError is tied low.
module pc_fetch_sequencer #(
    parameter int                ADDR_W       = 10,
    parameter int                FLUSH_CYCLES = 2,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iStall,
    input  logic              iJumpTaken,
    input  logic              iBranchTaken,
    input  logic              iCall,
    input  logic              iRet,
    input  logic [ADDR_W-1:0] iJumpAddress,
    input  logic [5:0]        iBranchOffset,
    input  logic [ADDR_W-1:0] iBranchIP,
    output logic [ADDR_W-1:0] oIP,
    output logic              oIPValid,
    output logic              oFlush,
    output logic [1:0]        oState,
    output logic              oRasError
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ip, ip_nxt;
    logic              valid, valid_nxt;
    logic              flush, flush_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic              redirect;

    // Branch target: sign-magnitude offset, magnitude zero-extended, wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] base,
                                                        input logic [5:0]        offset);
        logic [ADDR_W-1:0] mag;
        mag = ADDR_W'(offset[4:0]);
        return offset[5] ? (base - mag) : (base + mag);
    endfunction

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_wp, ras_rd;
    logic [CNT_W-1:0]  ras_cnt;
    logic              ras_full, ras_empty;
    logic [ADDR_W-1:0] ras_top;
    logic              do_push, do_pop;
    logic              ras_err, ras_err_nxt;

    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    assign ras_rd    = (ras_wp == '0) ? PTR_W'(RAS_DEPTH - 1) : (ras_wp - PTR_W'(1));
    assign ras_top   = ras_mem[ras_rd];
`else
    logic unused_ras_cfg;
    assign unused_ras_cfg = iRet ^ (RAS_DEPTH == 0);
`endif

    // Next-state, next-IP and output decode; one redirect winner per cycle.
    always_comb begin
        state_nxt = state;
        ip_nxt    = ip;
        valid_nxt = valid;
        flush_nxt = flush;
        cnt_nxt   = cnt;
        redirect  = 1'b0;
`ifdef PC_RAS_EN
        do_push     = 1'b0;
        do_pop      = 1'b0;
        ras_err_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_nxt = RUN;
                valid_nxt = 1'b1;
            end
            RUN: begin
                if (iJumpTaken) begin
                    ip_nxt   = iJumpAddress;
                    redirect = 1'b1;
                end else if (iCall) begin
                    ip_nxt   = iJumpAddress;
                    redirect = 1'b1;
`ifdef PC_RAS_EN
                    do_push     = 1'b1;
                    ras_err_nxt = ras_full;
`endif
                end
`ifdef PC_RAS_EN
                else if (iRet) begin
                    ip_nxt      = ras_empty ? RESET_VECTOR : ras_top;
                    redirect    = 1'b1;
                    do_pop      = 1'b1;
                    ras_err_nxt = ras_empty;
                end
`endif
                else if (iBranchTaken) begin
                    ip_nxt   = branch_target(iBranchIP, iBranchOffset);
                    redirect = 1'b1;
                end else if (!iStall) begin
                    ip_nxt = ip + ADDR_W'(1);
                end
                if (redirect) begin
                    state_nxt = FLUSH;
                    flush_nxt = 1'b1;
                    valid_nxt = 1'b0;
                    cnt_nxt   = 3'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) begin
                    state_nxt = RUN;
                    flush_nxt = 1'b0;
                    valid_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                flush_nxt = 1'b0;
            end
        endcase
    end

    // State, IP and flush-counter registers; Reset forces the idle state from anywhere.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            ip    <= RESET_VECTOR;
            valid <= 1'b0;
            flush <= 1'b0;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            ip    <= ip_nxt;
            valid <= valid_nxt;
            flush <= flush_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef PC_RAS_EN
    // RAS control: write pointer, occupancy and the one-cycle error pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
            ras_err <= 1'b0;
        end else begin
            ras_err <= ras_err_nxt;
            if (do_push) begin
                ras_wp <= (ras_wp == PTR_W'(RAS_DEPTH - 1)) ? '0 : (ras_wp + PTR_W'(1));
                if (!ras_full) begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end else if (do_pop && !ras_empty) begin
                ras_wp  <= ras_rd;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // RAS storage: a push when full lands on the oldest slot, overwriting it.
    always_ff @(posedge Clock) begin
        if (do_push) begin
            ras_mem[ras_wp] <= iBranchIP + ADDR_W'(1);
        end
    end

    assign oRasError = ras_err;
`else
    assign oRasError = 1'b0;
`endif

    assign oIP      = ip;
    assign oIPValid = valid;
    assign oFlush   = flush;
    assign oState   = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: vector table, directed corner sequences and
// randomized traffic, all checked against a behavioural reference model.
// Honours PC_RAS_EN the same way the design does.
module tb_pc_fetch_sequencer;

    localparam int AW = 10;
    localparam int FC = 2;
    localparam int RD = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iStall = 1'b0, iJumpTaken = 1'b0, iBranchTaken = 1'b0;
    logic          iCall = 1'b0, iRet = 1'b0;
    logic [AW-1:0] iJumpAddress = '0;
    logic [5:0]    iBranchOffset = '0;
    logic [AW-1:0] iBranchIP = '0;
    logic [AW-1:0] oIP;
    logic          oIPValid, oFlush, oRasError;
    logic [1:0]    oState;

    pc_fetch_sequencer #(
        .ADDR_W(AW), .FLUSH_CYCLES(FC), .RESET_VECTOR(10'h000), .RAS_DEPTH(RD)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iStall(iStall), .iJumpTaken(iJumpTaken),
        .iBranchTaken(iBranchTaken), .iCall(iCall), .iRet(iRet),
        .iJumpAddress(iJumpAddress), .iBranchOffset(iBranchOffset), .iBranchIP(iBranchIP),
        .oIP(oIP), .oIPValid(oIPValid), .oFlush(oFlush), .oState(oState), .oRasError(oRasError)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 flushing; flush_left = flush cycles still to show.
    int            m_mode = 0;
    int            m_flush_left = 0;
    logic [AW-1:0] m_ip = '0;
    logic          m_valid = 1'b0, m_flush = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_ras[$];

    typedef struct {
        logic          rst, stall, jump, branch, call, ret;
        logic [AW-1:0] addr;
        logic [5:0]    off;
        logic [AW-1:0] bip;
        logic [AW-1:0] e_ip;
        logic          e_v, e_f;
        logic [1:0]    e_st;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic jump, input logic branch,
                         input logic call, input logic ret, input logic [AW-1:0] addr,
                         input logic [5:0] off, input logic [AW-1:0] bip);
        Reset = rst; iStall = stall; iJumpTaken = jump; iBranchTaken = branch;
        iCall = call; iRet = ret; iJumpAddress = addr; iBranchOffset = off; iBranchIP = bip;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic          redir;
        logic [AW-1:0] tgt;
        int            t;
        redir = 1'b0;
        tgt   = '0;
        m_err = 1'b0;
        if (Reset) begin
            m_mode = 0; m_ip = '0; m_valid = 1'b0; m_flush = 1'b0; m_flush_left = 0;
            m_ras.delete();
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1; m_valid = 1'b1;
        end else if (m_mode == 1) begin
            if (iJumpTaken) begin
                tgt = iJumpAddress; redir = 1'b1;
            end else if (iCall) begin
                tgt = iJumpAddress; redir = 1'b1;
`ifdef PC_RAS_EN
                if (m_ras.size() == RD) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back(AW'((int'(iBranchIP) + 1) % 1024));
`endif
            end
`ifdef PC_RAS_EN
            else if (iRet) begin
                redir = 1'b1;
                if (m_ras.size() == 0) begin
                    tgt = '0; m_err = 1'b1;
                end else begin
                    tgt = m_ras.pop_back();
                end
            end
`endif
            else if (iBranchTaken) begin
                t = int'(iBranchIP) + (iBranchOffset[5] ? -int'(iBranchOffset[4:0]) : int'(iBranchOffset[4:0]));
                tgt = AW'(((t % 1024) + 1024) % 1024);
                redir = 1'b1;
            end else if (!iStall) begin
                m_ip = AW'((int'(m_ip) + 1) % 1024);
            end
            if (redir) begin
                m_ip = tgt; m_flush = 1'b1; m_valid = 1'b0; m_mode = 2; m_flush_left = FC;
            end
        end else begin
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_mode = 1; m_flush = 1'b0; m_valid = 1'b1;
            end
        end
    endtask

    // One clock: sample just after the edge, step the model, compare every output.
    task automatic step();
        @(posedge Clock);
        #1;
        model_edge();
        check("model_ip",    32'(oIP),       32'(m_ip));
        check("model_valid", 32'(oIPValid),  32'(m_valid));
        check("model_flush", 32'(oFlush),    32'(m_flush));
        check("model_state", 32'(oState),    32'(m_mode));
        check("model_raserr", 32'(oRasError), 32'(m_err));
    endtask

    task automatic idle_step();
        drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
        step();
    endtask

    task automatic add(input logic rst, input logic stall, input logic jump, input logic branch,
                       input logic call, input logic ret, input logic [AW-1:0] addr,
                       input logic [5:0] off, input logic [AW-1:0] bip,
                       input logic [AW-1:0] e_ip, input logic e_v, input logic e_f, input logic [1:0] e_st);
        vec_t v;
        v.rst = rst; v.stall = stall; v.jump = jump; v.branch = branch; v.call = call; v.ret = ret;
        v.addr = addr; v.off = off; v.bip = bip;
        v.e_ip = e_ip; v.e_v = e_v; v.e_f = e_f; v.e_st = e_st;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset, idle, free-run, stall
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 1);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, AW'(i), 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h005, 1, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h005, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h006, 1, 0, 1);
        // Backward branch 0x010 - 3
        add(0, 0, 0, 1, 0, 0, 0, 6'b100011, 10'h010, 10'h00D, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h00D, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h00D, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h00E, 1, 0, 1);
        // Jump beats branch; branch and stall during flush ignored
        add(0, 0, 1, 1, 0, 0, 10'h200, 6'b000100, 10'h010, 10'h200, 0, 1, 2);
        add(0, 0, 0, 1, 0, 0, 0, 6'b000100, 10'h050, 10'h200, 0, 1, 2);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 10'h200, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h201, 1, 0, 1);
        // Wrap at top of address space
        add(0, 0, 1, 0, 0, 0, 10'h3FE, 0, 0, 10'h3FE, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h3FE, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h3FE, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h3FF, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 1);
        // Negative branch wraps below zero, then Reset mid-flush
        add(0, 0, 0, 1, 0, 0, 0, 6'b100101, 10'h001, 10'h3FC, 0, 1, 2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h000, 1, 0, 1);
        // Redirect overrides stall
        add(0, 1, 1, 0, 0, 0, 10'h123, 0, 0, 10'h123, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h123, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h123, 1, 0, 1);
        // Call redirects to the jump address
        add(0, 0, 0, 0, 1, 0, 10'h155, 0, 10'h020, 10'h155, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h155, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h155, 1, 0, 1);
        // Forward branch wraps past the top
        add(0, 0, 0, 1, 0, 0, 0, 6'b011111, 10'h3F0, 10'h00F, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h00F, 0, 1, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h00F, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 10'h010, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].jump, tbl[i].branch, tbl[i].call, tbl[i].ret,
                  tbl[i].addr, tbl[i].off, tbl[i].bip);
            step();
            check($sformatf("vec%0d_ip", i),    32'(oIP),      32'(tbl[i].e_ip));
            check($sformatf("vec%0d_valid", i), 32'(oIPValid), 32'(tbl[i].e_v));
            check($sformatf("vec%0d_flush", i), 32'(oFlush),   32'(tbl[i].e_f));
            check($sformatf("vec%0d_state", i), 32'(oState),   32'(tbl[i].e_st));
        end

`ifdef PC_RAS_EN
        // Call/return pair, overflow on the fifth call, underflow on an empty stack
        drive(1, 0, 0, 0, 0, 0, '0, '0, '0); step();
        idle_step();
        drive(0, 0, 0, 0, 1, 0, 10'h100, '0, 10'h020); step();
        check("ras_call_ip", 32'(oIP), 32'h100);
        idle_step(); idle_step();
        drive(0, 0, 0, 0, 0, 1, '0, '0, '0); step();
        check("ras_ret_ip", 32'(oIP), 32'h021);
        check("ras_ret_flush", 32'(oFlush), 32'd1);
        idle_step(); idle_step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 10'h100, '0, AW'(10'h030 + i)); step();
            check($sformatf("ras_push%0d_err", i), 32'(oRasError), (i == 4) ? 32'd1 : 32'd0);
            idle_step();
            check($sformatf("ras_push%0d_err_clear", i), 32'(oRasError), 32'd0);
            idle_step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, '0, '0, '0); step();
            check($sformatf("ras_pop%0d_ip", i), 32'(oIP), 32'(10'h035 - i));
            check($sformatf("ras_pop%0d_err", i), 32'(oRasError), 32'd0);
            idle_step(); idle_step();
        end
        drive(0, 0, 0, 0, 0, 1, '0, '0, '0); step();
        check("ras_empty_ip", 32'(oIP), 32'h000);
        check("ras_empty_err", 32'(oRasError), 32'd1);
        idle_step(); idle_step();
`else
        // Return is ignored; call behaves as a jump; ret+branch lets the branch act
        drive(1, 0, 0, 0, 0, 0, '0, '0, '0); step();
        idle_step();
        drive(0, 0, 0, 0, 0, 1, 10'h300, '0, '0); step();
        check("ret_ignored_ip", 32'(oIP), 32'h001);
        check("ret_ignored_flush", 32'(oFlush), 32'd0);
        check("ret_ignored_err", 32'(oRasError), 32'd0);
        drive(0, 0, 0, 1, 0, 1, '0, 6'b000010, 10'h040); step();
        check("ret_branch_ip", 32'(oIP), 32'h042);
        check("ret_branch_flush", 32'(oFlush), 32'd1);
        idle_step(); idle_step();
        drive(0, 0, 0, 1, 1, 0, 10'h2AA, 6'b000010, 10'h040); step();
        check("call_beats_branch_ip", 32'(oIP), 32'h2AA);
        idle_step(); idle_step();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(199) == 0),
                  ($urandom_range(3) == 0),
                  ($urandom_range(15) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(15) == 0),
                  ($urandom_range(11) == 0),
                  AW'($urandom), 6'($urandom), AW'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
